// File: rtl/fir_filter_rtc.sv
// Transposed-form FIR with clock-enabled 4-stage pipeline and double-buffered run-time coefficients.
// Output rounds half-up by OUT_SHIFT; FIR_OUT_SAT_EN selects saturation, otherwise the output wraps.
module fir_filter_rtc #(
  parameter int NUM_TAPS   = 16,
  parameter int DATA_WIDTH = 16,
  parameter int COEF_WIDTH = 16,
  parameter int OUT_WIDTH  = 24,
  parameter int OUT_SHIFT  = 8
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         i_valid,
  input  logic signed [DATA_WIDTH-1:0] i_data,
  input  logic                         i_flush,
  input  logic                         i_coef_we,
  input  logic [$clog2(NUM_TAPS)-1:0]  i_coef_addr,
  input  logic signed [COEF_WIDTH-1:0] i_coef_data,
  input  logic                         i_coef_commit,
  output logic                         o_valid,
  output logic signed [OUT_WIDTH-1:0]  o_data,
  output logic                         o_sat
);

  localparam int AW        = $clog2(NUM_TAPS);
  localparam int PW        = DATA_WIDTH + COEF_WIDTH;
  localparam int ACC_WIDTH = DATA_WIDTH + COEF_WIDTH + $clog2(NUM_TAPS);
  localparam int TW        = ACC_WIDTH + 1;
  localparam int EW        = (TW > OUT_WIDTH) ? TW : OUT_WIDTH;
  localparam logic signed [TW-1:0] RND = TW'((TW'(1) << OUT_SHIFT) >> 1);

  logic signed [COEF_WIDTH-1:0] shadow_q [NUM_TAPS];
  logic signed [COEF_WIDTH-1:0] active_q [NUM_TAPS];
  logic signed [PW-1:0]         x_q;
  logic signed [PW-1:0]         p_q [NUM_TAPS];
  logic signed [ACC_WIDTH-1:0]  acc_q [NUM_TAPS];
  logic                         v1_q, v2_q, v3_q;
  logic                         o_valid_q;
  logic signed [OUT_WIDTH-1:0]  o_data_q, o_data_d;
  logic signed [TW-1:0]         acc_ext, t;
  logic signed [EW-1:0]         t_ext;
  logic                         coef_in_range;

  if ((1 << AW) == NUM_TAPS) begin : g_addr_full
    assign coef_in_range = 1'b1;
  end else begin : g_addr_part
    assign coef_in_range = (int'(i_coef_addr) < NUM_TAPS);
  end

  // Commit samples the shadow bank before any same-cycle write lands in it.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int k = 0; k < NUM_TAPS; k++) begin
        shadow_q[k] <= '0;
        active_q[k] <= '0;
      end
    end else begin
      if (i_coef_commit) begin
        for (int k = 0; k < NUM_TAPS; k++) active_q[k] <= shadow_q[k];
      end
      if (i_coef_we && coef_in_range) shadow_q[i_coef_addr] <= i_coef_data;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst || i_flush) begin
      x_q  <= '0;
      v1_q <= 1'b0;
      v2_q <= 1'b0;
      v3_q <= 1'b0;
      for (int k = 0; k < NUM_TAPS; k++) begin
        p_q[k]   <= '0;
        acc_q[k] <= '0;
      end
    end else begin
      v1_q <= i_valid;
      v2_q <= v1_q;
      v3_q <= v2_q;
      if (i_valid) x_q <= PW'(i_data);
      if (v1_q) begin
        for (int k = 0; k < NUM_TAPS; k++) p_q[k] <= x_q * PW'(active_q[k]);
      end
      // Chain advances once per accepted sample, so gaps never shift history.
      if (v2_q) begin
        for (int k = 0; k < NUM_TAPS - 1; k++) acc_q[k] <= ACC_WIDTH'(p_q[k]) + acc_q[k+1];
        acc_q[NUM_TAPS-1] <= ACC_WIDTH'(p_q[NUM_TAPS-1]);
      end
    end
  end

  always_comb begin
    acc_ext = {acc_q[0][ACC_WIDTH-1], acc_q[0]};
    t       = (acc_ext + RND) >>> OUT_SHIFT;
    t_ext   = EW'(t);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_valid_q <= 1'b0;
      o_data_q  <= '0;
    end else if (i_flush) begin
      o_valid_q <= 1'b0;
    end else begin
      o_valid_q <= v3_q;
      if (v3_q) o_data_q <= o_data_d;
    end
  end

`ifdef FIR_OUT_SAT_EN
  localparam logic signed [EW-1:0] OMAX = {{(EW-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [EW-1:0] OMIN = {{(EW-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};
  logic o_sat_q, o_sat_d;

  always_comb begin
    o_sat_d  = 1'b1;
    o_data_d = t_ext[OUT_WIDTH-1:0];
    if (t_ext > OMAX)      o_data_d = OMAX[OUT_WIDTH-1:0];
    else if (t_ext < OMIN) o_data_d = OMIN[OUT_WIDTH-1:0];
    else                   o_sat_d  = 1'b0;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst)                      o_sat_q <= 1'b0;
    else if (!i_flush && v3_q)      o_sat_q <= o_sat_d;
  end

  assign o_sat = o_sat_q;
`else
  logic unused_t_hi;
  assign unused_t_hi = ^t_ext;
  assign o_data_d    = t_ext[OUT_WIDTH-1:0];
  assign o_sat       = 1'b0;
`endif

  assign o_valid = o_valid_q;
  assign o_data  = o_data_q;

endmodule

// File: tb/tb_fir_filter_rtc.sv
// Directed bench: impulse, gapped input, scaling, coefficient commit, saturation/wrap, reset and flush.
module tb_fir_filter_rtc;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst, vld, flush, we, commit;
  logic signed [15:0] data, cdata;
  logic [2:0]         addr;
  logic               oa_valid, oa_sat, ob_valid, ob_sat;
  logic signed [15:0] oa_data;
  logic signed [23:0] ob_data;

  int total  = 0;
  int passed = 0;
  bit sv[64], sc[64], sf[64], es[64];
  int sd[64], ex[64];
  int cv[8];

  fir_filter_rtc #(.NUM_TAPS(8), .DATA_WIDTH(16), .COEF_WIDTH(16), .OUT_WIDTH(16), .OUT_SHIFT(0)) dut_a (
    .i_clk(clk), .i_rst(rst), .i_valid(vld), .i_data(data), .i_flush(flush),
    .i_coef_we(we), .i_coef_addr(addr), .i_coef_data(cdata), .i_coef_commit(commit),
    .o_valid(oa_valid), .o_data(oa_data), .o_sat(oa_sat));

  fir_filter_rtc #(.NUM_TAPS(8), .DATA_WIDTH(16), .COEF_WIDTH(16), .OUT_WIDTH(24), .OUT_SHIFT(8)) dut_b (
    .i_clk(clk), .i_rst(rst), .i_valid(vld), .i_data(data), .i_flush(flush),
    .i_coef_we(we), .i_coef_addr(addr), .i_coef_data(cdata), .i_coef_commit(commit),
    .o_valid(ob_valid), .o_data(ob_data), .o_sat(ob_sat));

  task automatic chk(input string tag, input longint got, input longint exp);
    total++;
    assert (got === exp) passed++;
    else $error("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_stim();
    for (int i = 0; i < 64; i++) begin
      sv[i] = 0; sc[i] = 0; sf[i] = 0; es[i] = 0; sd[i] = 0; ex[i] = 0;
    end
  endtask

  task automatic load(input bit do_commit);
    for (int k = 0; k < 8; k++) begin
      we = 1; addr = 3'(k); cdata = 16'(cv[k]);
      tick();
    end
    we = 0;
    if (do_commit) begin
      commit = 1; tick(); commit = 0;
    end
  endtask

  task automatic do_flush();
    flush = 1; tick(); flush = 0;
  endtask

  // Plays n stimulus cycles plus a drain; output must follow each accepted sample by 4 edges.
  task automatic run(input int n, input int nexp, input bit sel, input string tag);
    bit     sr[4];
    int     ei;
    bit     have;
    longint last, got_d;
    logic   got_v, got_s;
    sr = '{default:0}; ei = 0; have = 0; last = 0;
    for (int c = 0; c < n + 4; c++) begin
      vld    = (c < n) ? sv[c] : 1'b0;
      data   = (c < n) ? 16'(sd[c]) : 16'sd0;
      commit = (c < n) ? sc[c] : 1'b0;
      flush  = (c < n) ? sf[c] : 1'b0;
      tick();
      sr[3] = sr[2]; sr[2] = sr[1]; sr[1] = sr[0]; sr[0] = vld;
      if (flush) sr = '{default:0};
      got_v = sel ? ob_valid : oa_valid;
      got_d = sel ? ob_data : oa_data;
      got_s = sel ? ob_sat : oa_sat;
      chk({tag, ".vld"}, longint'(got_v), longint'(sr[3]));
      if (sr[3]) begin
        if (ei < nexp) begin
          chk({tag, ".dat"}, got_d, ex[ei]);
          chk({tag, ".sat"}, longint'(got_s), longint'(es[ei]));
          last = ex[ei];
        end
        ei++;
        have = 1;
      end else if (have) begin
        chk({tag, ".hold"}, got_d, last);
      end
    end
    vld = 0; commit = 0; flush = 0;
    chk({tag, ".count"}, ei, nexp);
  endtask

  initial begin
    rst = 1; vld = 0; flush = 0; we = 0; commit = 0; data = 0; cdata = 0; addr = 0;
    tick(); tick();
    rst = 0;
    chk("rst.a_vld", oa_valid, 0);
    chk("rst.a_dat", oa_data, 0);
    chk("rst.a_sat", oa_sat, 0);
    chk("rst.b_vld", ob_valid, 0);
    chk("rst.b_dat", ob_data, 0);
    chk("rst.b_sat", ob_sat, 0);

    // Impulse response, back-to-back samples
    for (int k = 0; k < 8; k++) cv[k] = k + 1;
    load(1);
    clear_stim();
    for (int i = 0; i < 9; i++) sv[i] = 1;
    sd[0] = 1;
    for (int i = 0; i < 8; i++) ex[i] = i + 1;
    run(9, 9, 0, "imp");

    // Same impulse with a sample every third cycle
    clear_stim();
    for (int i = 0; i < 9; i++) sv[3*i] = 1;
    sd[0] = 1;
    for (int i = 0; i < 8; i++) ex[i] = i + 1;
    run(27, 9, 0, "gap");

    // Commit mid-stream: all-1 active, all-2 shadow committed at sample 20
    for (int k = 0; k < 8; k++) cv[k] = 1;
    load(1);
    for (int k = 0; k < 8; k++) cv[k] = 2;
    load(0);
    do_flush();
    clear_stim();
    for (int i = 0; i < 30; i++) begin
      sv[i] = 1; sd[i] = 1;
      ex[i] = (i < 8) ? i + 1 : (i < 20) ? 8 : (i < 28) ? i - 11 : 16;
    end
    sc[20] = 1;
    run(30, 30, 0, "cmt");

    // Write and commit together: the write stays out of the active bank
    do_flush();
    we = 1; addr = 3'd0; cdata = 16'sd5; commit = 1;
    tick();
    we = 0; commit = 0;
    clear_stim();
    for (int i = 0; i < 9; i++) sv[i] = 1;
    sd[0] = 1;
    for (int i = 0; i < 8; i++) ex[i] = 2;
    run(9, 9, 0, "wc1");
    commit = 1; tick(); commit = 0;
    for (int i = 0; i < 8; i++) ex[i] = (i == 0) ? 5 : 2;
    run(9, 9, 0, "wc2");

    // Rounded shift by 8 on the 24-bit instance
    for (int k = 0; k < 8; k++) cv[k] = 256;
    load(1);
    do_flush();
    clear_stim();
    for (int i = 0; i < 10; i++) begin
      sv[i] = 1; sd[i] = 1000;
      ex[i] = (i < 8) ? 1000 * (i + 1) : 8000;
    end
    run(10, 10, 1, "shf");

    // Full-scale input on the 16-bit instance
    for (int k = 0; k < 8; k++) cv[k] = 32767;
    load(1);
    do_flush();
    clear_stim();
    for (int i = 0; i < 16; i++) begin
      sv[i] = 1; sd[i] = (i < 8) ? 32767 : -32768;
    end
`ifdef FIR_OUT_SAT_EN
    for (int i = 0; i < 16; i++) begin
      ex[i] = (i < 11) ? 32767 : -32768;
      es[i] = 1;
    end
`else
    for (int i = 0; i < 8; i++) ex[i] = i + 1;
    ex[8]  = -32761; ex[9]  = 6; ex[10] = -32763; ex[11] = 4;
    ex[12] = -32765; ex[13] = 2; ex[14] = -32767; ex[15] = 0;
`endif
    run(16, 16, 0, "sat");

    // Reset mid-stream clears outputs and both coefficient banks
    for (int k = 0; k < 8; k++) cv[k] = k + 1;
    load(1);
    do_flush();
    vld = 1; data = 16'sd3;
    tick();
    vld = 0;
    tick(); tick(); tick();
    chk("pre_rst.vld", oa_valid, 1);
    chk("pre_rst.dat", oa_data, 3);
    vld = 1; data = 16'sd4;
    tick();
    vld = 0; rst = 1;
    tick();
    rst = 0;
    chk("rst2.a_vld", oa_valid, 0);
    chk("rst2.a_dat", oa_data, 0);
    chk("rst2.a_sat", oa_sat, 0);
    chk("rst2.b_vld", ob_valid, 0);
    chk("rst2.b_dat", ob_data, 0);
    clear_stim();
    sv[0] = 1; sd[0] = 5; sv[1] = 1; sd[1] = 6; sv[2] = 1; sd[2] = 7;
    run(3, 3, 0, "rz");

    // Flush drops in-flight and same-cycle samples, holds o_data, leaves coefficients
    load(1);
    clear_stim();
    sv[0] = 1; sd[0] = 7;
    sv[1] = 1; sd[1] = 7;
    sv[4] = 1; sd[4] = 9; sf[4] = 1;
    sv[5] = 1; sd[5] = 1;
    for (int i = 6; i < 14; i++) sv[i] = 1;
    ex[0] = 7;
    for (int i = 1; i < 9; i++) ex[i] = i;
    ex[9] = 0;
    run(14, 10, 0, "fls");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
